// File: rtl/as_mem_ctrl.sv
// as_mem_ctrl: access-memory stage engine.
// Takes the AS pipeline register contents (flag, instruction, ALU result, rs2) and issues one
// load or store per flagged instruction on a req/ack data bus. Store data is lane-replicated
// with byte enables. Load data is byte/half selected and sign- or zero-extended.
// stall_o holds the AS register until the access finishes.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   acess_mem_flag_i              AS register holds a load/store
//   inst_i, alu_res_i, rs2_data_i instruction, effective address, store data
//   mem_req_o/we/addr/wdata/be    bus request fields, held while BUSY
//   mem_ack_i/err_i/rdata_i       bus completion, error and read data
//   ld_data_o, ld_valid_o         load result and its 1-cycle update strobe
//   stall_o                       FLOW_STOP request
//   exc_o                         1-cycle exception pulse
module as_mem_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acess_mem_flag_i,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ack_i,
  input  logic              mem_err_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_valid_o,
  output logic              stall_o,
  output logic              exc_o
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic [3:0]          be_q, be_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                we_q, we_d;
  logic                ld_valid_q, ld_valid_d;
  logic                exc_q, exc_d;

  // Instruction decode
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [1:0]        off;
  logic              is_load, is_store, f3_legal, aligned, req_ok;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic              unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign off         = alu_res_i[1:0];
  assign is_load     = (opcode == 7'b0000011);
  assign is_store    = (opcode == 7'b0100011);
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

  always_comb begin
    f3_legal = 1'b0;
    if (is_load) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (is_store) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
  end

  // funct3[1:0] gives the access size for both loads and stores
  always_comb begin
    case (funct3[1:0])
      2'b01:   aligned = (off[0] == 1'b0);
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign req_ok = f3_legal && aligned;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2_data_i;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << off;
          st_wdata = {4{rs2_data_i[7:0]}};
        end
        2'b01: begin
          st_be    = off[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{rs2_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction uses the captured funct3/offset, not the live instruction
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  assign ld_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    exc_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acess_mem_flag_i) begin
          if (req_ok) begin
            addr_d   = {alu_res_i[DATA_W-1:2], 2'b00};
            wdata_d  = st_wdata;
            be_d     = st_be;
            we_d     = is_store;
            funct3_d = funct3;
            off_d    = off;
            cnt_d    = '0;
            state_d  = StBusy;
          end else begin
            exc_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        if (mem_ack_i) begin
          state_d = StDone;
          if (mem_err_i) begin
            exc_d = 1'b1;
            if (!we_q) ld_data_d = '0;
          end else if (!we_q) begin
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end
        end else if (cnt_q == CntLast) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      exc_q      <= exc_d;
    end
  end

  assign mem_req_o   = (state_q == StBusy);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign ld_data_o   = ld_data_q;
  assign ld_valid_o  = ld_valid_q;
  assign exc_o       = exc_q;
  // Gated by rst so a still-asserted flag cannot hold the pipe during reset
  assign stall_o     = !rst && (((state_q == StIdle) && acess_mem_flag_i) || (state_q == StBusy));

endmodule
